if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Instruction queue between the fetch stage and the decode stage of the RISC-V core.
- Buffers up to DEPTH fetched (PC, instruction) pairs with valid/ready handshakes on both sides, which decouples fetch from decode stalls.
- Predecodes each instruction once, when it is written, into control-flow and illegal-encoding flags for decode.
- Supports a synchronous flush for branch/jump redirects.

Parameters:
- N, 32, width of PC and instruction words.
- DEPTH, 4, number of entries; power of two, minimum 2.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous discard of all queued entries
- in_valid  input  1  fetch presents a valid entry
- in_ready  output  1  queue can accept an entry this cycle
- in_pc  input  N  PC of the fetched instruction
- in_inst  input  N  fetched instruction word
- out_valid  output  1  head entry valid toward decode
- out_ready  input  1  decode consumes head this cycle
- out_pc  output  N  PC of head entry
- out_inst  output  N  instruction of head entry
- out_is_ctrl  output  1  head opcode is JAL (1101111), JALR (1100111) or BRANCH (1100011)
- out_illegal  output  1  head inst[1:0] != 2'b11 (compressed/invalid encoding)
- count  output  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Storage: DEPTH entries, each holding pc[N-1:0], inst[N-1:0], is_ctrl, illegal.
- Pointers: write pointer and read pointer, each $clog2(DEPTH) bits, wrap modulo DEPTH. Count register 0..DEPTH.
- Reset (asynchronous): pointers = 0, count = 0. Stored entries need not be cleared.
- Reset values of outputs: in_ready = 1, out_valid = 0, out_pc = 0, out_inst = 0, out_is_ctrl = 0, out_illegal = 0.
- in_ready = (count != DEPTH). It depends only on registered state and has no combinational path from out_ready.
- out_valid = (count != 0). When out_valid = 0, out_pc, out_inst, out_is_ctrl and out_illegal are forced to 0.
- Push = in_valid & in_ready & ~flush. On push, the entry is written at the write pointer and the write pointer increments.
- Predecode flags are computed from in_inst at write time and stored; they are never recomputed from the head.
- Pop = out_valid & out_ready & ~flush. On pop, the read pointer increments.
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Latency: no bypass. An entry pushed in cycle t is visible on out_* in cycle t+1 at the earliest. Empty-to-valid latency is 1 cycle.
- Full with out_ready = 1: pop occurs, push is refused (in_ready = 0). in_ready returns to 1 the next cycle.
- Empty with in_valid = 1 and out_ready = 1: push only, no pop.
- Order: strict FIFO. The read pointer wraps from DEPTH-1 to 0 with no gap or duplication.
- Flush: on the next edge, pointers = 0 and count = 0. Any push or pop in the same cycle is discarded. out_valid = 0 in the following cycle.
- Reset asserted mid-stream: state clears immediately (asynchronously). out_valid drops in the same cycle reset rises.
- Flush asserted on a cycle with count = 0: no effect beyond pointer reinitialisation.
- Held inputs: in_valid is allowed to stay high while in_ready = 0. Fetch holds in_pc/in_inst stable until accepted.

Test Plan:
- Reset then idle: out_valid = 0, in_ready = 1, count = 0, out_inst = 0x00000000.
- Push PC 0x0, 0x4, 0x8, 0xC with instructions 0x00000013, 0x0000006F, 0x00008067, 0x00000063, out_ready = 0 → count = 4, in_ready = 0. Then out_ready = 1 for 4 cycles → heads appear in order with out_is_ctrl = 0, 1, 1, 1.
- Queue full and in_valid = 1 with out_ready = 1 for one cycle → exactly one pop, no push, count = 3, and the held fetch entry is accepted the next cycle.
- Continuous in_valid = out_ready = 1 for 20 cycles with incrementing PC → count stable at 1 after the first cycle, out_pc sequence 0x0, 0x4, ... with no loss across pointer wrap.
- count = 3 with flush = 1 and in_valid = 1 simultaneously → next cycle count = 0, out_valid = 0, and the flushed-cycle entry is absent from later output.
- Push inst 0x00000001 → out_illegal = 1. Assert reset while count = 2 → out_valid = 0 immediately and count = 0 after reset deasserts.

Source files
------------

// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction queue.
// The queue uses the slave modport; the fetch/decode side uses master.
interface if_id_queue_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_pc;
  logic [N-1:0] in_inst;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_pc;
  logic [N-1:0] out_inst;
  logic         out_is_ctrl;
  logic         out_illegal;

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_is_ctrl, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_is_ctrl, out_illegal
  );
endinterface

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction FIFO with write-time predecode and synchronous flush.
// Handshake outputs depend only on registered state, so there is no ready-to-ready path.
module if_id_queue #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  if_id_queue_if.slave           q,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  function automatic logic is_ctrl_f(input logic [N-1:0] inst);
    logic [6:0] op;
    op = inst[6:0];
    return (op == 7'b1101111) || (op == 7'b1100111) || (op == 7'b1100011);
  endfunction

  function automatic logic is_illegal_f(input logic [N-1:0] inst);
    return inst[1:0] != 2'b11;
  endfunction

  logic [N-1:0]  pc_mem_r   [DEPTH];
  logic [N-1:0]  inst_mem_r [DEPTH];
  logic          ctrl_mem_r [DEPTH];
  logic          ill_mem_r  [DEPTH];

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic [AW-1:0] wr_ptr_nx_s;
  logic [AW-1:0] rd_ptr_nx_s;
  logic [CW-1:0] count_nx_s;
  logic          in_ready_s;
  logic          out_valid_s;
  logic          push_s;
  logic          pop_s;

  assign in_ready_s  = (count_r != FULL_CNT);
  assign out_valid_s = (count_r != {CW{1'b0}});
  assign push_s      = q.in_valid & in_ready_s & ~flush;
  assign pop_s       = out_valid_s & q.out_ready & ~flush;
  assign count       = count_r;

  // Next pointer and occupancy values for a normal (non-flush) cycle.
  always_comb begin
    wr_ptr_nx_s = wr_ptr_r;
    rd_ptr_nx_s = rd_ptr_r;
    count_nx_s  = count_r;
    if (push_s) begin
      wr_ptr_nx_s = wr_ptr_r + AW'(1);
    end else begin
      wr_ptr_nx_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nx_s = rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_nx_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_nx_s = count_r + CW'(1);
      2'b01:   count_nx_s = count_r - CW'(1);
      default: count_nx_s = count_r;
    endcase
  end

  // Pointer and occupancy registers; flush reinitialises and overrides any push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_nx_s;
      rd_ptr_r <= rd_ptr_nx_s;
      count_r  <= count_nx_s;
    end
  end

  // Entry storage; predecode flags are captured once, at write time.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]   <= q.in_pc;
      inst_mem_r[wr_ptr_r] <= q.in_inst;
      ctrl_mem_r[wr_ptr_r] <= is_ctrl_f(q.in_inst);
      ill_mem_r[wr_ptr_r]  <= is_illegal_f(q.in_inst);
    end
  end

  // Head presentation; payload is zeroed whenever the queue is empty.
  always_comb begin
    q.in_ready    = in_ready_s;
    q.out_valid   = out_valid_s;
    q.out_pc      = {N{1'b0}};
    q.out_inst    = {N{1'b0}};
    q.out_is_ctrl = 1'b0;
    q.out_illegal = 1'b0;
    if (out_valid_s) begin
      q.out_pc      = pc_mem_r[rd_ptr_r];
      q.out_inst    = inst_mem_r[rd_ptr_r];
      q.out_is_ctrl = ctrl_mem_r[rd_ptr_r];
      q.out_illegal = ill_mem_r[rd_ptr_r];
    end else begin
      q.out_pc      = {N{1'b0}};
      q.out_inst    = {N{1'b0}};
      q.out_is_ctrl = 1'b0;
      q.out_illegal = 1'b0;
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_if_id_queue;
  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [CW-1:0] count;

  if_id_queue_if #(.N(N)) bus ();

  if_id_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .q     (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] pc;
    logic [N-1:0] inst;
  } entry_t;

  entry_t       mq[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic         acc;
  logic [N-1:0] next_pc;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic ref_ctrl(input logic [N-1:0] inst);
    return (inst[6:0] == 7'h6F) || (inst[6:0] == 7'h67) || (inst[6:0] == 7'h63);
  endfunction

  // Compare outputs against the model mid-cycle, then advance the model across the edge.
  task automatic cycle();
    int           sz;
    logic [N-1:0] epc;
    logic [N-1:0] einst;
    logic         push;
    logic         pop;
    entry_t       e;
    @(negedge clk);
    sz    = mq.size();
    epc   = (sz != 0) ? mq[0].pc   : '0;
    einst = (sz != 0) ? mq[0].inst : '0;
    check_eq("count",       64'(count),            64'(sz));
    check_eq("in_ready",    64'(bus.in_ready),     64'(sz != DEPTH));
    check_eq("out_valid",   64'(bus.out_valid),    64'(sz != 0));
    check_eq("out_pc",      64'(bus.out_pc),       64'(epc));
    check_eq("out_inst",    64'(bus.out_inst),     64'(einst));
    check_eq("out_is_ctrl", 64'(bus.out_is_ctrl),  64'((sz != 0) && ref_ctrl(einst)));
    check_eq("out_illegal", 64'(bus.out_illegal),  64'((sz != 0) && (einst[1:0] != 2'b11)));
    push = bus.in_valid && (sz != DEPTH) && !flush && !reset;
    pop  = (sz != 0) && bus.out_ready && !flush && !reset;
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc   = bus.in_pc;
        e.inst = bus.in_inst;
        mq.push_back(e);
      end
    end
    acc = push;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [N-1:0] pc, input logic [N-1:0] inst);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_inst  = inst;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) cycle();
  endtask

  function automatic logic [N-1:0] rand_inst();
    logic [N-1:0] inst;
    inst = $urandom;
    case ($urandom_range(0, 3))
      0:       inst[6:0] = 7'h6F;
      1:       inst[6:0] = 7'h67;
      2:       inst[6:0] = 7'h63;
      default: inst[6:0] = 7'h13;
    endcase
    if ($urandom_range(0, 7) == 0) inst[1:0] = 2'($urandom_range(0, 2));
    return inst;
  endfunction

  logic [N-1:0] dir_inst [4];

  initial begin
    dir_inst[0] = 32'h0000_0013;
    dir_inst[1] = 32'h0000_006F;
    dir_inst[2] = 32'h0000_8067;
    dir_inst[3] = 32'h0000_0063;
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_inst   = '0;
    bus.out_ready = 1'b0;
    #1;
    cycle();
    reset = 1'b0;
    cycle();
    check_eq("idle_out_inst", 64'(bus.out_inst), 64'h0);

    // Fill with out_ready low, then drain in order.
    for (int i = 0; i < 4; i++) begin
      offer(32'(4 * i), dir_inst[i]);
      cycle();
    end
    bus.in_valid = 1'b0;
    check_eq("full_count", 64'(count), 64'd4);
    check_eq("full_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("dir_is_ctrl", 64'(bus.out_is_ctrl), (i == 0) ? 64'd0 : 64'd1);
      cycle();
    end

    // Full queue with a held fetch entry: one pop, no push, then acceptance.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(32'h100 + 32'(4 * i), 32'h0000_0013);
      cycle();
    end
    offer(32'h110, 32'h0000_0063);
    cycle();
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    check_eq("pop_on_full_count", 64'(count), 64'd3);
    cycle();
    bus.in_valid = 1'b0;
    check_eq("held_accepted_count", 64'(count), 64'd4);
    drain();

    // Streaming across pointer wrap.
    next_pc = '0;
    bus.out_ready = 1'b1;
    offer(next_pc, 32'h0000_0013);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (acc) begin
        next_pc = next_pc + 32'd4;
        offer(next_pc, 32'h0000_0013);
      end
    end
    drain();

    // Flush at count 3 with a simultaneous push.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(32'h200 + 32'(4 * i), 32'h0000_0013);
      cycle();
    end
    offer(32'h300, 32'h0000_006F);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    cycle();
    check_eq("post_flush_valid", 64'(bus.out_valid), 64'd0);
    offer(32'h400, 32'h0000_0013);
    cycle();
    bus.in_valid = 1'b0;
    check_eq("post_flush_head", 64'(bus.out_pc), 64'h400);
    drain();

    // Illegal encoding, then asynchronous reset with two entries queued.
    bus.out_ready = 1'b0;
    offer(32'h500, 32'h0000_0001);
    cycle();
    offer(32'h504, 32'h0000_0013);
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    check_eq("illegal_head", 64'(bus.out_illegal), 64'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("async_rst_count", 64'(count), 64'd0);
    mq.delete();
    cycle();
    reset = 1'b0;
    cycle();

    // Random traffic with held-until-accepted fetch behaviour.
    next_pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      if (!bus.in_valid && ($urandom_range(0, 3) != 0)) begin
        offer(next_pc, rand_inst());
        next_pc = next_pc + 32'd4;
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 19) == 0);
      cycle();
      if (acc) bus.in_valid = 1'b0;
    end
    flush = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
